// File: rtl/prog_loader_mem.sv
// Program memory and checksum-verified byte loader for the TD4 core.
// Parks the core on JMP 0 until a verified program is held.
module prog_loader_mem #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 4,
    parameter logic [DATA_W-1:0] PARK_INSN = 8'hF0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              LD_START,
    input  logic              LD_VALID,
    input  logic [DATA_W-1:0] LD_DATA,
    output logic              LD_READY,
    output logic              LD_DONE,
    output logic              LD_ERR,
    output logic              CPU_RUN,
    input  logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DATA
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_RUN,
        S_ERR
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [DATA_W-1:0]   r_sum;
    logic                r_done;
    logic                r_err;
    logic                r_run;
    logic [DATA_W-1:0]   r_mem [0:DEPTH-1];

    logic                w_ready;
    logic                w_accept;
    logic [DATA_W-1:0]   w_chk;

    assign w_ready  = ((r_state == S_LOAD) || (r_state == S_CHECK)) && !LD_START;
    assign w_accept = LD_VALID && w_ready;
    assign w_chk    = r_sum + LD_DATA;

    // Loader FSM: restart, byte collection, checksum verdict, registered status.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_sum    <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_run    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (LD_START) begin
                r_state  <= S_LOAD;
                r_wr_ptr <= '0;
                r_sum    <= '0;
                r_err    <= 1'b0;
                r_run    <= 1'b0;
            end else begin
                unique case (r_state)
                    S_LOAD: begin
                        if (w_accept) begin
                            r_sum    <= w_chk;
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                            if (r_wr_ptr == '1) begin
                                r_state <= S_CHECK;
                            end
                        end
                    end
                    S_CHECK: begin
                        if (w_accept) begin
                            if (w_chk == '0) begin
                                r_state <= S_RUN;
                                r_run   <= 1'b1;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_ERR;
                                r_err   <= 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Program storage: written only with program bytes, never the checksum.
    always_ff @(posedge CLK) begin
        if (w_accept && (r_state == S_LOAD)) begin
            r_mem[r_wr_ptr] <= LD_DATA;
        end
    end

    assign LD_READY = w_ready;
    assign LD_DONE  = r_done;
    assign LD_ERR   = r_err;
    assign CPU_RUN  = r_run;
    assign MEM_DATA = (r_state == S_RUN) ? r_mem[MEM_ADDR] : PARK_INSN;

endmodule

// File: tb/tb_prog_loader_mem.sv
// Scoreboard bench for prog_loader_mem.
// Stimulus queues expectations; a negedge monitor consumes them.
module tb_prog_loader_mem;

    logic       CLK;
    logic       RST_N;
    logic       LD_START;
    logic       LD_VALID;
    logic [7:0] LD_DATA;
    logic       LD_READY;
    logic       LD_DONE;
    logic       LD_ERR;
    logic       CPU_RUN;
    logic [3:0] MEM_ADDR;
    logic [7:0] MEM_DATA;

    int n_vec = 0;
    int n_bad = 0;

    localparam int P_DATA  = 0;
    localparam int P_RUN   = 1;
    localparam int P_DONE  = 2;
    localparam int P_ERR   = 3;
    localparam int P_READY = 4;

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] exp;
    } probe_t;

    probe_t     q_pr[$];
    logic [7:0] q_acc[$];
    int         q_done[$];
    probe_t     p;
    logic [7:0] act;
    logic [7:0] ea;

    prog_loader_mem dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .LD_START (LD_START),
        .LD_VALID (LD_VALID),
        .LD_DATA  (LD_DATA),
        .LD_READY (LD_READY),
        .LD_DONE  (LD_DONE),
        .LD_ERR   (LD_ERR),
        .CPU_RUN  (CPU_RUN),
        .MEM_ADDR (MEM_ADDR),
        .MEM_DATA (MEM_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic void chk(string name, logic [7:0] a, logic [7:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", name, a, e);
        end
    endfunction

    // Monitor: probes, accepted bytes and done pulses, all at negedge.
    always @(negedge CLK) begin
        while (q_pr.size() > 0) begin
            p = q_pr.pop_front();
            case (p.sel)
                P_DATA:  act = MEM_DATA;
                P_RUN:   act = {7'd0, CPU_RUN};
                P_DONE:  act = {7'd0, LD_DONE};
                P_ERR:   act = {7'd0, LD_ERR};
                default: act = {7'd0, LD_READY};
            endcase
            chk(p.name, act, p.exp);
        end
        if (LD_VALID && LD_READY) begin
            if (q_acc.size() == 0) begin
                chk("unexpected_accept", LD_DATA, 8'hxx);
            end else begin
                ea = q_acc.pop_front();
                chk("accept_data", LD_DATA, ea);
            end
        end
        if (LD_DONE) begin
            if (q_done.size() == 0) begin
                chk("unexpected_done", 8'd1, 8'd0);
            end else begin
                void'(q_done.pop_front());
                chk("done_event", 8'd1, 8'd1);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic probe(string name, int sel, logic [7:0] e);
        probe_t t;
        t.name = name;
        t.sel  = sel;
        t.exp  = e;
        q_pr.push_back(t);
    endtask

    task automatic do_start();
        LD_START = 1'b1;
        tick();
        LD_START = 1'b0;
    endtask

    task automatic send(logic [7:0] d, int maxgap);
        int g;
        g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        LD_VALID = 1'b0;
        repeat (g) tick();
        LD_VALID = 1'b1;
        LD_DATA  = d;
        q_acc.push_back(d);
        tick();
        LD_VALID = 1'b0;
    endtask

    task automatic stream16(logic [7:0] base, int maxgap);
        for (int i = 0; i < 16; i++) begin
            send(base + 8'(i), maxgap);
        end
    endtask

    task automatic sweep(logic [7:0] base, bit parked);
        for (int i = 0; i < 16; i++) begin
            MEM_ADDR = 4'(i);
            probe("mem_read", P_DATA, parked ? 8'hF0 : base + 8'(i));
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        RST_N    = 1'b0;
        LD_START = 1'b0;
        LD_VALID = 1'b0;
        LD_DATA  = 8'h00;
        MEM_ADDR = 4'd0;
        tick();
        tick();
        RST_N = 1'b1;

        // Reset state and parked sweep with LD_VALID asserted in IDLE
        probe("rst_run", P_RUN, 8'd0);
        probe("rst_done", P_DONE, 8'd0);
        probe("rst_err", P_ERR, 8'd0);
        probe("rst_ready", P_READY, 8'd0);
        LD_VALID = 1'b1;
        LD_DATA  = 8'h5A;
        sweep(8'h00, 1'b1);
        LD_VALID = 1'b0;

        // Good load 00..0F, checksum 88
        do_start();
        probe("load_ready", P_READY, 8'd1);
        probe("load_park", P_DATA, 8'hF0);
        stream16(8'h00, 0);
        q_done.push_back(1);
        send(8'h88, 0);
        probe("done_hi", P_DONE, 8'd1);
        probe("run_hi", P_RUN, 8'd1);
        MEM_ADDR = 4'd5;
        probe("same_cycle_read5", P_DATA, 8'h05);
        tick();
        probe("done_lo", P_DONE, 8'd0);
        probe("run_ready", P_READY, 8'd0);
        tick();
        sweep(8'h00, 1'b0);

        // Bad checksum 89
        do_start();
        stream16(8'h00, 0);
        send(8'h89, 0);
        MEM_ADDR = 4'd5;
        probe("err_hi", P_ERR, 8'd1);
        probe("err_run", P_RUN, 8'd0);
        probe("err_park", P_DATA, 8'hF0);
        probe("err_ready", P_READY, 8'd0);
        tick();
        probe("err_hold", P_ERR, 8'd1);
        tick();
        do_start();
        probe("err_clear", P_ERR, 8'd0);

        // Gapped load 10..1F, then LD_VALID asserted during RUN
        stream16(8'h10, 7);
        q_done.push_back(1);
        send(8'h88, 7);
        probe("gap_run", P_RUN, 8'd1);
        LD_VALID = 1'b1;
        LD_DATA  = 8'hC3;
        sweep(8'h10, 1'b0);
        LD_VALID = 1'b0;

        // Restart after 9 bytes with a byte offered in the start cycle
        do_start();
        for (int i = 0; i < 9; i++) begin
            send(8'h50 + 8'(i), 0);
        end
        LD_START = 1'b1;
        LD_VALID = 1'b1;
        LD_DATA  = 8'hEE;
        probe("start_ready", P_READY, 8'd0);
        tick();
        LD_START = 1'b0;
        LD_VALID = 1'b0;
        stream16(8'hA0, 0);
        q_done.push_back(1);
        send(8'h88, 0);
        MEM_ADDR = 4'd0;
        probe("restart_mem0", P_DATA, 8'hA0);
        tick();
        MEM_ADDR = 4'd15;
        probe("restart_mem15", P_DATA, 8'hAF);
        tick();

        // Async reset mid-CHECK
        do_start();
        stream16(8'h00, 0);
        probe("check_ready", P_READY, 8'd1);
        tick();
        RST_N = 1'b0;
        probe("arst_chk_ready", P_READY, 8'd0);
        probe("arst_chk_park", P_DATA, 8'hF0);
        probe("arst_chk_run", P_RUN, 8'd0);
        probe("arst_chk_err", P_ERR, 8'd0);
        tick();
        RST_N = 1'b1;
        tick();
        probe("post_rst_ready", P_READY, 8'd0);
        probe("post_rst_park", P_DATA, 8'hF0);
        tick();

        // Async reset mid-RUN, asserted between edges
        do_start();
        stream16(8'h00, 0);
        q_done.push_back(1);
        send(8'h88, 0);
        tick();
        MEM_ADDR = 4'd3;
        probe("pre_rst_read", P_DATA, 8'h03);
        tick();
        #2;
        RST_N = 1'b0;
        probe("arst_run_run", P_RUN, 8'd0);
        probe("arst_run_park", P_DATA, 8'hF0);
        probe("arst_run_done", P_DONE, 8'd0);
        tick();
        RST_N = 1'b1;
        LD_VALID = 1'b1;
        tick();
        probe("idle_ready", P_READY, 8'd0);
        probe("idle_park", P_DATA, 8'hF0);
        tick();
        LD_VALID = 1'b0;
        tick();
        tick();

        chk("acc_queue_empty", 8'(q_acc.size()), 8'd0);
        chk("done_queue_empty", 8'(q_done.size()), 8'd0);
        chk("probe_queue_empty", 8'(q_pr.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
